mo_pixel_serializer: RTL and testbench

//  Write-side feeder for the motion object horizontal line buffer: accepts 4-bitplane graphic ROM

---
 rtl/mo_gfx_pkg.sv | 42 ++++
 rtl/mo_word_shifter.sv | 61 ++++++
 rtl/mo_pixel_serializer.sv | 176 +++++++++++++++++
 tb/tb_mo_pixel_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mo_gfx_pkg.sv
// Shared types and helpers for the motion object pixel serializer.
// Graphic words carry 8 pixels as four bitplanes.
package mo_gfx_pkg;

    localparam int PIX_PER_WORD = 8;
    localparam int BPP          = 4;
    localparam int COLOR_W      = 3;
    localparam int CNT_W        = 6;
    localparam int WORD_W       = PIX_PER_WORD * BPP;

    localparam logic [BPP-1:0] TRANSP = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [BPP-1:0]     pix;
    } mosr_t;

    // Blank slot: colour 0 with the transparent code (7'h0F).
    localparam mosr_t MOSR_IDLE = '{color: '0, pix: TRANSP};

    // Pixel idx of a word; plane p is word[8p+7:8p], pixel i is bit (7-i).
    function automatic logic [BPP-1:0] pix_at(
        input logic [WORD_W-1:0] word,
        input logic [2:0]        idx,
        input logic              hflip
    );
        logic [2:0]     i;
        logic [BPP-1:0] p;
        i = hflip ? (3'd7 - idx) : idx;
        for (int b = 0; b < BPP; b++) begin
            p[b] = word[8*b + 7 - int'(i)];
        end
        return p;
    endfunction

endpackage

// File: rtl/mo_word_shifter.sv
// 8-pixel shift register: unpacks a word (with hflip) at load,
// then presents one pixel per shift on pix, lowest slot first.
module mo_word_shifter
    import mo_gfx_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       load,
    input  logic                       shift,
    input  logic [WORD_W-1:0]          word,
    input  logic                       hflip,
    input  logic [COLOR_W-1:0]         color_in,
    output logic [BPP-1:0]             pix,
    output logic [COLOR_W-1:0]         color,
    output logic                       empty,
    output logic                       last
);

    logic [PIX_PER_WORD-1:0][BPP-1:0] pix_q, pix_d;
    logic [COLOR_W-1:0]               color_q, color_d;
    logic [3:0]                       cnt_q, cnt_d;

    assign pix   = pix_q[0];
    assign color = color_q;
    assign empty = (cnt_q == 4'd0);
    assign last  = (cnt_q == 4'd1);

    // Flush beats load beats shift; load wins over the shift of slot 8.
    always_comb begin
        pix_d   = pix_q;
        color_d = color_q;
        cnt_d   = cnt_q;
        if (flush) begin
            cnt_d = 4'd0;
        end else if (load) begin
            for (int i = 0; i < PIX_PER_WORD; i++) begin
                pix_d[i] = pix_at(word, 3'(i), hflip);
            end
            color_d = color_in;
            cnt_d   = 4'd8;
        end else if (shift && !empty) begin
            pix_d = {TRANSP, pix_q[PIX_PER_WORD-1:1]};
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_q   <= '0;
            color_q <= '0;
            cnt_q   <= 4'd0;
        end else begin
            pix_q   <= pix_d;
            color_q <= color_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/mo_pixel_serializer.sv
// Line-buffer write feeder: hold register + shifter, emits
// {colour, pixel} at pixel rate with the LMPD_b transparency flag.
module mo_pixel_serializer
    import mo_gfx_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    input  logic               line_start,
    input  logic [CNT_W-1:0]   line_words,
    input  logic [WORD_W-1:0]  gfx_data,
    input  logic               gfx_hflip,
    input  logic [COLOR_W-1:0] gfx_color,
    input  logic               gfx_valid,
    output logic               gfx_ready,
    output logic [6:0]         mosr,
    output logic               mosr_valid,
    output logic               lmpd_b,
    output logic               line_done,
    output logic               underrun
);

    state_e             state_q, state_d;
    logic               hold_full_q, hold_full_d;
    logic [WORD_W-1:0]  hold_data_q, hold_data_d;
    logic               hold_flip_q, hold_flip_d;
    logic [COLOR_W-1:0] hold_color_q, hold_color_d;
    logic [CNT_W-1:0]   accepted_q, accepted_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   words_q, words_d;
    mosr_t              mosr_q, mosr_d;
    logic               mosr_valid_q, mosr_valid_d;
    logic               lmpd_b_q, lmpd_b_d;
    logic               fin_q, fin_d;
    logic               line_done_q, line_done_d;
    logic               underrun_q, underrun_d;
    logic               started_q, started_d;

    logic               accept, emit, sh_load;
    logic [BPP-1:0]     sh_pix;
    logic [COLOR_W-1:0] sh_color;
    logic               sh_empty, sh_last;

    assign gfx_ready = (state_q == ST_RUN) && !hold_full_q
                     && (accepted_q < words_q);
    assign accept    = gfx_valid && gfx_ready;
    assign emit      = pix_ce && (state_q == ST_RUN) && !sh_empty;
    assign sh_load   = hold_full_q && !line_start
                     && (sh_empty || (emit && sh_last));

    assign mosr       = mosr_q;
    assign mosr_valid = mosr_valid_q;
    assign lmpd_b     = lmpd_b_q;
    assign line_done  = line_done_q;
    assign underrun   = underrun_q;

    mo_word_shifter u_shifter (
        .clk      (clk),
        .reset    (reset),
        .flush    (line_start),
        .load     (sh_load),
        .shift    (emit),
        .word     (hold_data_q),
        .hflip    (hold_flip_q),
        .color_in (hold_color_q),
        .pix      (sh_pix),
        .color    (sh_color),
        .empty    (sh_empty),
        .last     (sh_last)
    );

    // Next state: line_start first, then accept, transfer and pixel slot.
    // Empty slots before the first pixel of a line are pipeline fill,
    // not an underrun.
    always_comb begin
        state_d      = state_q;
        hold_full_d  = hold_full_q;
        hold_data_d  = hold_data_q;
        hold_flip_d  = hold_flip_q;
        hold_color_d = hold_color_q;
        accepted_d   = accepted_q;
        remaining_d  = remaining_q;
        words_d      = words_q;
        mosr_d       = mosr_q;
        mosr_valid_d = mosr_valid_q;
        lmpd_b_d     = lmpd_b_q;
        fin_d        = 1'b0;
        line_done_d  = fin_q;
        underrun_d   = underrun_q;
        started_d    = started_q;
        if (line_start) begin
            state_d      = (line_words != '0) ? ST_RUN : ST_DONE;
            hold_full_d  = 1'b0;
            accepted_d   = '0;
            remaining_d  = line_words;
            words_d      = line_words;
            mosr_d       = MOSR_IDLE;
            mosr_valid_d = 1'b0;
            lmpd_b_d     = 1'b1;
            line_done_d  = 1'b0;
            underrun_d   = 1'b0;
            started_d    = 1'b0;
        end else begin
            if (sh_load) begin
                hold_full_d = 1'b0;
            end
            if (accept) begin
                hold_full_d  = 1'b1;
                hold_data_d  = gfx_data;
                hold_flip_d  = gfx_hflip;
                hold_color_d = gfx_color;
                if (accepted_q != '1) begin
                    accepted_d = accepted_q + 1'b1;
                end
            end
            if (emit) begin
                mosr_d       = '{color: sh_color, pix: sh_pix};
                mosr_valid_d = 1'b1;
                lmpd_b_d     = (sh_pix == TRANSP);
                started_d    = 1'b1;
                if (sh_last && remaining_q != '0) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        fin_d   = 1'b1;
                    end
                end
            end else if (pix_ce) begin
                mosr_d       = MOSR_IDLE;
                mosr_valid_d = 1'b0;
                lmpd_b_d     = 1'b1;
                if (state_q == ST_RUN && started_q) begin
                    underrun_d = 1'b1;
                end
            end
        end
    end

    // State, storage and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_full_q  <= 1'b0;
            hold_data_q  <= '0;
            hold_flip_q  <= 1'b0;
            hold_color_q <= '0;
            accepted_q   <= '0;
            remaining_q  <= '0;
            words_q      <= '0;
            mosr_q       <= MOSR_IDLE;
            mosr_valid_q <= 1'b0;
            lmpd_b_q     <= 1'b1;
            fin_q        <= 1'b0;
            line_done_q  <= 1'b0;
            underrun_q   <= 1'b0;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            hold_flip_q  <= hold_flip_d;
            hold_color_q <= hold_color_d;
            accepted_q   <= accepted_d;
            remaining_q  <= remaining_d;
            words_q      <= words_d;
            mosr_q       <= mosr_d;
            mosr_valid_q <= mosr_valid_d;
            lmpd_b_q     <= lmpd_b_d;
            fin_q        <= fin_d;
            line_done_q  <= line_done_d;
            underrun_q   <= underrun_d;
            started_q    <= started_d;
        end
    end

endmodule

// File: tb/tb_mo_pixel_serializer.sv
// Directed bench for mo_pixel_serializer.
// Word A: pixels 8..F, word B: pixels 0..7.
module tb_mo_pixel_serializer;
    import mo_gfx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic        line_start;
    logic [5:0]  line_words;
    logic [31:0] gfx_data;
    logic        gfx_hflip;
    logic [2:0]  gfx_color;
    logic        gfx_valid;
    logic        gfx_ready;
    logic [6:0]  mosr;
    logic        mosr_valid;
    logic        lmpd_b;
    logic        line_done;
    logic        underrun;

    localparam logic [31:0] WORD_A = 32'hFF0F3355;
    localparam logic [31:0] WORD_B = 32'h000F3355;

    int n_checks = 0;
    int n_fail   = 0;
    bit ce_div2  = 1'b0;
    bit found;

    mo_pixel_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .line_start (line_start),
        .line_words (line_words),
        .gfx_data   (gfx_data),
        .gfx_hflip  (gfx_hflip),
        .gfx_color  (gfx_color),
        .gfx_valid  (gfx_valid),
        .gfx_ready  (gfx_ready),
        .mosr       (mosr),
        .mosr_valid (mosr_valid),
        .lmpd_b     (lmpd_b),
        .line_done  (line_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ce_div2) pix_ce = ~pix_ce;
    endtask

    task automatic expect_px(input string tag,
                             input logic [6:0] exp);
        logic [3:0] p;
        p = exp[3:0];
        check({tag, "_mosr"}, 32'(mosr), 32'(exp));
        check({tag, "_vld"}, 32'(mosr_valid), 32'd1);
        check({tag, "_lmpd"}, 32'(lmpd_b), 32'(p == 4'hF));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_mosr"}, 32'(mosr), 32'h0F);
        check({tag, "_vld"}, 32'(mosr_valid), 32'd0);
        check({tag, "_lmpd"}, 32'(lmpd_b), 32'd1);
    endtask

    // Starts a line with a word offered; returns after the accept edge.
    task automatic start_line(input logic [5:0] words,
                              input logic [31:0] data,
                              input logic [2:0] col,
                              input logic flip);
        line_start = 1'b1;
        line_words = words;
        gfx_data   = data;
        gfx_color  = col;
        gfx_hflip  = flip;
        gfx_valid  = 1'b1;
        tick();
        line_start = 1'b0;
        check("ready_run", 32'(gfx_ready), 32'd1);
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        pix_ce     = 1'b1;
        line_start = 1'b0;
        line_words = '0;
        gfx_data   = '0;
        gfx_hflip  = 1'b0;
        gfx_color  = '0;
        gfx_valid  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_ready", 32'(gfx_ready), 32'd0);
        expect_idle("rst");
        check("rst_done", 32'(line_done), 32'd0);
        check("rst_under", 32'(underrun), 32'd0);

        // Single word, no flip.
        start_line(6'd1, WORD_A, 3'd5, 1'b0);
        gfx_valid = 1'b0;
        check("t1_ready_lo", 32'(gfx_ready), 32'd0);
        tick();
        expect_idle("t1_fill");
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_px("t1_px", {3'd5, 4'(8 + i)});
            check("t1_ndone", 32'(line_done), 32'd0);
        end
        tick();
        check("t1_done", 32'(line_done), 32'd1);
        expect_idle("t1_post");
        tick();
        check("t1_done_lo", 32'(line_done), 32'd0);
        check("t1_ready_end", 32'(gfx_ready), 32'd0);

        // Same word, hflip.
        start_line(6'd1, WORD_A, 3'd5, 1'b1);
        gfx_valid = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_px("t2_px", {3'd5, 4'(15 - i)});
        end
        tick();
        check("t2_done", 32'(line_done), 32'd1);

        // Two words back to back, no gap.
        start_line(6'd2, WORD_A, 3'd5, 1'b0);
        gfx_data  = WORD_B;
        gfx_color = 3'd2;
        tick();
        check("t3_ready2", 32'(gfx_ready), 32'd1);
        expect_idle("t3_fill");
        tick();
        gfx_valid = 1'b0;
        expect_px("t3_a", {3'd5, 4'd8});
        for (int i = 1; i < 8; i++) begin
            tick();
            expect_px("t3_a", {3'd5, 4'(8 + i)});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_px("t3_b", {3'd2, 4'(i)});
        end
        check("t3_under", 32'(underrun), 32'd0);
        tick();
        check("t3_done", 32'(line_done), 32'd1);
        check("t3_under2", 32'(underrun), 32'd0);

        // Two words requested, only one supplied.
        start_line(6'd2, WORD_A, 3'd5, 1'b0);
        gfx_valid = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_px("t4_px", {3'd5, 4'(8 + i)});
        end
        check("t4_under0", 32'(underrun), 32'd0);
        tick();
        expect_idle("t4_gap");
        check("t4_under1", 32'(underrun), 32'd1);
        check("t4_ndone", 32'(line_done), 32'd0);
        tick();
        tick();
        check("t4_sticky", 32'(underrun), 32'd1);
        line_start = 1'b1;
        line_words = 6'd0;
        tick();
        line_start = 1'b0;
        check("t4_clear", 32'(underrun), 32'd0);

        // Half-rate pixel enable, restart mid-word.
        ce_div2 = 1'b1;
        start_line(6'd1, WORD_A, 3'd5, 1'b0);
        gfx_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick();
            if (mosr_valid) found = 1'b1;
        end
        check("t5_first", 32'(found), 32'd1);
        for (int i = 0; i < 4; i++) begin
            expect_px("t5_a", {3'd5, 4'(8 + i)});
            tick();
            expect_px("t5_hold", {3'd5, 4'(8 + i)});
            if (i < 3) tick();
        end
        line_start = 1'b1;
        line_words = 6'd3;
        tick();
        line_start = 1'b0;
        expect_idle("t5_rst");
        check("t5_ready", 32'(gfx_ready), 32'd1);
        check("t5_under", 32'(underrun), 32'd0);
        check("t5_done", 32'(line_done), 32'd0);
        ce_div2 = 1'b0;
        pix_ce  = 1'b1;

        // Reset in the middle of a running line.
        start_line(6'd2, WORD_A, 3'd5, 1'b0);
        gfx_valid = 1'b0;
        tick();
        tick();
        tick();
        expect_px("t6_run", {3'd5, 4'd9});
        reset = 1'b1;
        tick();
        expect_idle("t6_rst");
        check("t6_ready", 32'(gfx_ready), 32'd0);
        check("t6_done", 32'(line_done), 32'd0);
        check("t6_under", 32'(underrun), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        expect_idle("t6_after");
        check("t6_ready2", 32'(gfx_ready), 32'd0);
        check("t6_under2", 32'(underrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_checks, n_fail);
        $finish;
    end

endmodule
